// File: rtl/datapath_sequencer.sv
// Instruction sequencer: buffers packed ALU instructions in a FIFO and issues each to the
// 4-register datapath as a READ/WRITE pair. Optional result capture under `DP_SEQ_CAPTURE_EN`.
module datapath_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [8:0]  in_instr,
   output logic        in_ready,
   input  logic        flush,
   output logic [1:0]  addr1,
   output logic [1:0]  addr2,
   output logic [1:0]  addr3,
   output logic [2:0]  aluControl,
   output logic        wr,
   output logic        busy,
   output logic        retire
`ifdef DP_SEQ_CAPTURE_EN
   ,
   input  logic [31:0] dp_result,
   output logic [31:0] last_result,
   output logic        last_zero
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   state_e           state_q;
   logic [8:0]       ir_q;
   logic             wr_q;
   logic             retire_q;

   logic [8:0]       fifo_mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [8:0]       head;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full && !flush;
   assign push     = in_valid && in_ready;
   // A slot opens for the next instruction only when the FSM is idle or finishing a write.
   assign pop      = !empty && !flush && ((state_q == S_IDLE) || (state_q == S_WRITE));
   assign head     = fifo_mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= in_instr;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ir_q        <= '0;
         wr_q        <= 1'b0;
         retire_q    <= 1'b0;
`ifdef DP_SEQ_CAPTURE_EN
         last_result <= '0;
         last_zero   <= 1'b1;
`endif
      end else begin
         wr_q     <= 1'b0;
         retire_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (pop) begin
                  ir_q    <= head;
                  state_q <= S_READ;
               end
            end
            S_READ: begin
               wr_q    <= 1'b1;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               retire_q <= 1'b1;
`ifdef DP_SEQ_CAPTURE_EN
               last_result <= dp_result;
               last_zero   <= (dp_result == 32'd0);
`endif
               if (pop) begin
                  ir_q    <= head;
                  state_q <= S_READ;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign aluControl = ir_q[8:6];
   assign addr3      = ir_q[5:4];
   assign addr1      = ir_q[3:2];
   assign addr2      = ir_q[1:0];
   // Reset held during WRITE must not let the datapath commit.
   assign wr         = wr_q && rst;
   assign retire     = retire_q;
   assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed scenarios plus random traffic, checked each cycle
// against a queue-based model of issue order and instruction phases.
module tb_datapath_sequencer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [8:0]  in_instr;
   logic        in_ready;
   logic        flush;
   logic [1:0]  addr1, addr2, addr3;
   logic [2:0]  aluControl;
   logic        wr, busy, retire;
`ifdef DP_SEQ_CAPTURE_EN
   logic [31:0] dp_result;
   logic [31:0] last_result;
   logic        last_zero;
`endif

   always #5 clk = ~clk;

   datapath_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
      .in_ready(in_ready), .flush(flush), .addr1(addr1), .addr2(addr2),
      .addr3(addr3), .aluControl(aluControl), .wr(wr), .busy(busy), .retire(retire)
`ifdef DP_SEQ_CAPTURE_EN
      , .dp_result(dp_result), .last_result(last_result), .last_zero(last_zero)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Model: pending queue, plus the one instruction in flight and how far along it is.
   logic [8:0]  mq [$];
   logic [8:0]  m_ir = '0;
   bit          m_inflight = 0;
   bit          m_writing = 0;
   bit          m_retire = 0;
   logic [31:0] m_lr = '0;
   bit          m_lz = 1;
   int          m_accepted = 0;
   int          m_retired = 0;
   int          dut_retired = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input logic [8:0] ins, input bit f,
                             input logic [31:0] res);
      bit push;
      if (!r) begin
         mq.delete();
         m_ir = '0;
         m_inflight = 0;
         m_writing = 0;
         m_retire = 0;
         m_lr = '0;
         m_lz = 1;
         return;
      end
      push = v && (mq.size() < DEPTH) && !f;
      m_retire = m_inflight && m_writing;
      if (m_retire) begin
         m_lr = res;
         m_lz = (res == 32'd0);
         m_retired++;
      end
      if (f) mq.delete();
      if (m_inflight && !m_writing) begin
         m_writing = 1;
      end else if (mq.size() > 0) begin
         m_ir = mq.pop_front();
         m_inflight = 1;
         m_writing = 0;
      end else begin
         m_inflight = 0;
         m_writing = 0;
      end
      if (push) begin
         mq.push_back(ins);
         m_accepted++;
      end
   endtask

   task automatic cycle(input bit r, input bit v, input logic [8:0] ins, input bit f,
                        input logic [31:0] res);
      rst = r;
      in_valid = v;
      in_instr = ins;
      flush = f;
`ifdef DP_SEQ_CAPTURE_EN
      dp_result = res;
`endif
      #1;
      if (!r) chk("wr_forced_low_in_reset", {31'd0, wr}, 32'd0);
      else    chk("in_ready_pre", {31'd0, in_ready}, {31'd0, (mq.size() < DEPTH) && !f});
      @(posedge clk);
      model_step(r, v, ins, f, res);
      #1;
      if (retire === 1'b1) dut_retired++;
      chk("addr1", {30'd0, addr1}, {30'd0, m_ir[3:2]});
      chk("addr2", {30'd0, addr2}, {30'd0, m_ir[1:0]});
      chk("addr3", {30'd0, addr3}, {30'd0, m_ir[5:4]});
      chk("aluControl", {29'd0, aluControl}, {29'd0, m_ir[8:6]});
      chk("wr", {31'd0, wr}, {31'd0, m_inflight && m_writing});
      chk("retire", {31'd0, retire}, {31'd0, m_retire});
      chk("busy", {31'd0, busy}, {31'd0, m_inflight || (mq.size() > 0)});
      chk("in_ready_post", {31'd0, in_ready}, {31'd0, (mq.size() < DEPTH) && !f});
`ifdef DP_SEQ_CAPTURE_EN
      chk("last_result", last_result, m_lr);
      chk("last_zero", {31'd0, last_zero}, {31'd0, m_lz});
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 9'd0, 0, 32'd0);
   endtask

   initial begin
      // Reset with valid held: nothing may be accepted.
      cycle(0, 1, 9'h1AB, 0, 32'd7);
      cycle(0, 1, 9'h0F3, 0, 32'd7);
      idle(2);
      chk("no_push_in_reset", {31'd0, busy}, 32'd0);

      // Single ADD R0 = R1 + R2.
      cycle(1, 1, 9'b000_00_01_10, 0, 32'd0);
      cycle(1, 0, 9'd0, 0, 32'd0);
      chk("single_addr1", {30'd0, addr1}, 32'd1);
      chk("single_addr2", {30'd0, addr2}, 32'd2);
      idle(5);

      // Back-to-back three instructions with capture values 5 then 0 then 9.
      cycle(1, 1, 9'b001_01_10_11, 0, 32'd0);
      cycle(1, 1, 9'b010_10_11_00, 0, 32'd0);
      cycle(1, 1, 9'b011_11_00_01, 0, 32'd0);
      cycle(1, 0, 9'd0, 0, 32'd5);
      cycle(1, 0, 9'd0, 0, 32'd5);
      cycle(1, 0, 9'd0, 0, 32'd0);
      cycle(1, 0, 9'd0, 0, 32'd0);
      cycle(1, 0, 9'd0, 0, 32'd9);
      cycle(1, 0, 9'd0, 0, 32'd9);
      idle(3);

      // Backpressure: valid held for 8 cycles, then drain.
      for (int i = 0; i < 8; i++) cycle(1, 1, 9'($urandom), 0, $urandom);
      idle(14);

      // Flush while the first instruction is in READ.
      cycle(1, 1, 9'h155, 0, 32'd0);
      cycle(1, 1, 9'h0AA, 0, 32'd0);
      cycle(1, 1, 9'h133, 1, 32'd0);
      idle(5);

      // Reset landing while an instruction is in WRITE.
      cycle(1, 1, 9'h1FF, 0, 32'd0);
      cycle(1, 0, 9'd0, 0, 32'd0);
      cycle(1, 0, 9'd0, 0, 32'd0);
      cycle(0, 0, 9'd0, 0, 32'h1234);
      idle(3);

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         bit r, v, f;
         r = ($urandom_range(0, 99) >= 2);
         v = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 99) < 5);
         cycle(r, v, 9'($urandom), f, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      end
      idle(14);
      chk("drained_busy", {31'd0, busy}, 32'd0);
      chk("retire_count", dut_retired, m_retired);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
